// File: rtl/request_unit.sv
// request_unit: sequences one-at-a-time instruction and data memory requests
// for the single-cycle datapath, gates PC advancement and latches halt.
module request_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IFETCH  = 2'd0,
    S_DACCESS = 2'd1,
    S_HALTED  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_next_state;
  logic             r_rd_q;
  logic             r_wr_q;
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mem_op;
  logic             w_pc_en;

  assign w_mem_op  = MemRead || MemWrite;
  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
  assign pc_en     = w_pc_en;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IFETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; halt outranks a memory op on the same fetch
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IFETCH: begin
        if (ihit && halt) begin
          w_next_state = S_HALTED;
        end else if (ihit && w_mem_op) begin
          w_next_state = S_DACCESS;
        end
      end
      S_DACCESS: begin
        if (dhit) begin
          w_next_state = S_IFETCH;
        end
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_IFETCH;
    endcase
  end

  // Output decode: enables are Moore, pc_en is Mealy on the hit
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    halted  = 1'b0;
    w_pc_en = 1'b0;
    case (r_state)
      S_IFETCH: begin
        imemREN = 1'b1;
        w_pc_en = ihit && !halt && !w_mem_op;
      end
      S_DACCESS: begin
        dmemREN = r_rd_q && !r_wr_q;
        dmemWEN = r_wr_q;
        w_pc_en = dhit;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
    if (RST) begin
      w_pc_en = 1'b0;
    end
  end

  // Access-type latches; a read+write request degrades to write only
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_q <= 1'b0;
      r_wr_q <= 1'b0;
    end else if (r_state == S_IFETCH && ihit && !halt && w_mem_op) begin
      r_rd_q <= MemRead && !MemWrite;
      r_wr_q <= MemWrite;
    end else if (r_state == S_DACCESS && dhit) begin
      r_rd_q <= 1'b0;
      r_wr_q <= 1'b0;
    end
  end

  // Saturating retire counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr_cnt <= '0;
    end else if (w_pc_en && r_instr_cnt != LP_CNT_MAX) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  // Saturating data-stall counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_DACCESS && !dhit && r_stall_cnt != LP_CNT_MAX) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: table of per-cycle vectors plus a
// saturation sequence on a narrow-counter instance.
module tb_request_unit;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        dhit;
  logic        MemRead;
  logic        MemWrite;
  logic        halt;

  logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
  logic [31:0] instr_cnt, stall_cnt;

  logic        n_imemREN, n_dmemREN, n_dmemWEN, n_pc_en, n_halted;
  logic [2:0]  n_instr_cnt, n_stall_cnt;

  int checks = 0;
  int errors = 0;

  request_unit dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halted(halted),
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  request_unit #(.CNT_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
    .imemREN(n_imemREN), .dmemREN(n_dmemREN), .dmemWEN(n_dmemWEN),
    .pc_en(n_pc_en), .halted(n_halted),
    .instr_cnt(n_instr_cnt), .stall_cnt(n_stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, ih, dh, mr, mw, hl;
    logic        e_im, e_dr, e_dw, e_pc, e_halted;
    int unsigned e_ic, e_sc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, ih, dh, mr, mw, hl,
                              input logic e_im, e_dr, e_dw, e_pc, e_halted,
                              input int unsigned e_ic, e_sc);
    vec_t v;
    v.rst = rst; v.ih = ih; v.dh = dh; v.mr = mr; v.mw = mw; v.hl = hl;
    v.e_im = e_im; v.e_dr = e_dr; v.e_dw = e_dw; v.e_pc = e_pc;
    v.e_halted = e_halted; v.e_ic = e_ic; v.e_sc = e_sc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ih, dh, mr, mw, hl);
    RST = rst; ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw; halt = hl;
  endtask

  initial begin
    // Fields: rst ih dh mr mw hl | imem dren dwen pc halted | icnt scnt
    add(1,0,0,0,0,0, 1,0,0,0,0, 0,0);              // in reset
    add(1,1,0,0,0,0, 1,0,0,0,0, 0,0);              // ihit under reset: no pc_en
    for (int k = 0; k < 5; k++)                    // ALU stream
      add(0,1,0,0,0,0, 1,0,0,1,0, k,0);
    add(0,0,0,0,0,0, 1,0,0,0,0, 5,0);              // idle
    add(0,1,0,1,0,0, 1,0,0,0,0, 5,0);              // load fetch
    add(0,1,0,0,0,1, 0,1,0,0,0, 5,0);              // DACCESS 1, ihit/halt ignored
    add(0,0,0,0,0,0, 0,1,0,0,0, 5,1);              // DACCESS 2
    add(0,0,1,0,0,0, 0,1,0,1,0, 5,2);              // DACCESS 3 with dhit
    add(0,0,0,0,0,0, 1,0,0,0,0, 6,2);              // back in IFETCH
    add(0,1,0,1,1,0, 1,0,0,0,0, 6,2);              // both flags
    add(0,0,0,0,0,0, 0,0,1,0,0, 6,2);              // write-only access
    add(0,0,1,0,0,0, 0,0,1,1,0, 6,3);              // dhit retires
    add(0,0,1,0,0,0, 1,0,0,0,0, 7,3);              // dhit ignored in IFETCH
    add(0,0,0,0,0,1, 1,0,0,0,0, 7,3);              // halt without ihit
    add(0,1,0,0,1,0, 1,0,0,0,0, 7,3);              // store fetch
    add(0,0,1,0,0,0, 0,0,1,1,0, 7,3);              // dhit on first DACCESS
    add(0,1,0,0,0,1, 1,0,0,0,0, 8,3);              // HALT fetch
    for (int k = 0; k < 10; k++)                   // halted ignores everything
      add(0,1,1,1,0,0, 0,0,0,0,1, 8,3);
    add(1,0,0,0,0,0, 0,0,0,0,1, 8,3);              // reset edge from HALTED
    add(0,0,0,0,0,0, 1,0,0,0,0, 0,0);
    add(0,1,0,0,1,0, 1,0,0,0,0, 0,0);              // store fetch
    add(0,0,0,0,0,0, 0,0,1,0,0, 0,0);              // DACCESS 1
    add(1,0,0,0,0,0, 0,0,1,0,0, 0,1);              // reset in DACCESS 2
    add(0,0,1,0,0,0, 1,0,0,0,0, 0,0);              // access abandoned

    drive(1,0,0,0,0,0);
    repeat (2) @(posedge CLK);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].ih, vecs[i].dh, vecs[i].mr, vecs[i].mw, vecs[i].hl);
      #1;
      chk("imemREN",   i, imemREN,   vecs[i].e_im);
      chk("dmemREN",   i, dmemREN,   vecs[i].e_dr);
      chk("dmemWEN",   i, dmemWEN,   vecs[i].e_dw);
      chk("pc_en",     i, pc_en,     vecs[i].e_pc);
      chk("halted",    i, halted,    vecs[i].e_halted);
      chk("instr_cnt", i, instr_cnt, vecs[i].e_ic);
      chk("stall_cnt", i, stall_cnt, vecs[i].e_sc);
      chk("one_hot_en", i, $countones({imemREN, dmemREN, dmemWEN}) <= 1, 1);
    end

    // Saturation: narrow counter holds at 7, wide one keeps counting
    @(negedge CLK);
    drive(1,0,0,0,0,0);
    @(negedge CLK);
    drive(0,1,0,0,0,0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("sat_pc_en", 100 + k, n_pc_en, 1);
      chk("sat_cnt3",  100 + k, n_instr_cnt, (k > 7) ? 7 : k);
      @(negedge CLK);
    end
    drive(0,0,0,0,0,0);
    #1;
    chk("sat_cnt3_final", 110, n_instr_cnt, 7);
    chk("sat_cnt32_final", 110, instr_cnt, 10);
    @(negedge CLK);
    chk("sat_cnt3_hold", 111, n_instr_cnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
